// File: rtl/spal_panel.sv
// spal_panel: front-panel controller; debounces power/speed buttons and drives the machine on/speed levels.
// Ports: clk, rst (async active-low), btn_power, btn_speed, state_in[1:0] -> on_off, speed, door_lock, fault, panel_state[1:0].
module spal_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_OFF_CYCLES = 64,
  parameter int STOP_TIMEOUT    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_power,
  input  logic       btn_speed,
  input  logic [1:0] state_in,
  output logic       on_off,
  output logic       speed,
  output logic       door_lock,
  output logic       fault,
  output logic [1:0] panel_state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int AW = $clog2(AUTO_OFF_CYCLES) + 1;
  localparam int SW = $clog2(STOP_TIMEOUT) + 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_OFF_CYCLES - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_ON   = 2'b01,
    S_STOP = 2'b10
  } state_t;

  // bit 0 = power, bit 1 = speed
  logic [1:0]    btn;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    level;
  logic [1:0]    level_q;
  logic [1:0]    press;
  logic [DW-1:0] db_cnt [2];

  assign btn = {btn_speed, btn_power};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      level     <= '0;
      level_q   <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // one-cycle pulse on a debounced rising edge only
  assign press = level & ~level_q;

  logic pwr_evt;
  logic spd_evt;
  logic idle;

  assign pwr_evt = press[0];
  assign spd_evt = press[1];
  assign idle    = (state_in == 2'b00);

  state_t        st_q, st_d;
  logic          on_q, on_d;
  logic          spd_q, spd_d;
  logic          flt_q, flt_d;
  logic          lock_q, lock_d;
  logic [AW-1:0] auto_q, auto_d;
  logic [SW-1:0] stop_q, stop_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= S_OFF;
      on_q   <= 1'b0;
      spd_q  <= 1'b0;
      flt_q  <= 1'b0;
      lock_q <= 1'b0;
      auto_q <= '0;
      stop_q <= '0;
    end else begin
      st_q   <= st_d;
      on_q   <= on_d;
      spd_q  <= spd_d;
      flt_q  <= flt_d;
      lock_q <= lock_d;
      auto_q <= auto_d;
      stop_q <= stop_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    on_d   = on_q;
    spd_d  = spd_q;
    flt_d  = flt_q;
    auto_d = auto_q;
    stop_d = stop_q;
    unique case (1'b1)
      st_q == S_OFF: begin
        if (pwr_evt) begin
          st_d   = S_ON;
          on_d   = 1'b1;
          spd_d  = 1'b0;
          flt_d  = 1'b0;
          auto_d = '0;
        end
      end
      st_q == S_ON: begin
        // power beats a speed press landing on the same cycle
        if (pwr_evt) begin
          st_d   = S_STOP;
          on_d   = 1'b0;
          stop_d = '0;
        end else if (spd_evt) begin
          spd_d  = ~spd_q;
          auto_d = '0;
        end else if (!idle) begin
          auto_d = '0;
        end else if (auto_q == AUTO_LAST) begin
          st_d   = S_STOP;
          on_d   = 1'b0;
          stop_d = '0;
        end else begin
          auto_d = auto_q + AW'(1);
        end
      end
      st_q == S_STOP: begin
        if (idle) begin
          st_d  = S_OFF;
          spd_d = 1'b0;
        end else if (stop_q == STOP_LAST) begin
          st_d  = S_OFF;
          spd_d = 1'b0;
          flt_d = 1'b1;
        end else begin
          stop_d = stop_q + SW'(1);
        end
      end
      default: begin
        st_d  = S_OFF;
        on_d  = 1'b0;
        spd_d = 1'b0;
      end
    endcase
  end

  // lock follows the next state so it is already set on the ON edge
  assign lock_d = (st_d != S_OFF);

  assign on_off      = on_q;
  assign speed       = spd_q;
  assign door_lock   = lock_q;
  assign fault       = flt_q;
  assign panel_state = st_q;

endmodule

// File: tb/tb_spal_panel.sv
// tb_spal_panel: directed test-plan sequences plus random button/state traffic,
// every cycle compared against an edge-indexed reference model.
module tb_spal_panel;

  localparam int D    = 4;
  localparam int AUTO = 64;
  localparam int STOP = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_power = 1'b0;
  logic       btn_speed = 1'b0;
  logic [1:0] state_in = 2'b00;
  logic       on_off;
  logic       speed;
  logic       door_lock;
  logic       fault;
  logic [1:0] panel_state;

  spal_panel #(
    .DEBOUNCE_CYCLES(D),
    .AUTO_OFF_CYCLES(AUTO),
    .STOP_TIMEOUT(STOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_power(btn_power),
    .btn_speed(btn_speed),
    .state_in(state_in),
    .on_off(on_off),
    .speed(speed),
    .door_lock(door_lock),
    .fault(fault),
    .panel_state(panel_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: edge-numbered history, timestamps instead of counters
  int        m_state;
  bit        m_spd;
  bit        m_fault;
  int        edge_n;
  int        mark;
  int        stop_start;
  bit [31:0] hist [2];
  bit        deb [2];
  bit        evt [2];
  int        last_chg [2];

  task automatic model_reset();
    m_state    = 0;
    m_spd      = 0;
    m_fault    = 0;
    edge_n     = 0;
    mark       = 0;
    stop_start = 0;
    for (int b = 0; b < 2; b++) begin
      hist[b]     = '0;
      deb[b]      = 0;
      evt[b]      = 0;
      last_chg[b] = 0;
    end
  endtask

  task automatic model_edge();
    bit pp;
    bit sp;
    bit ok;
    bit raw [2];
    if (!rst) begin
      model_reset();
      return;
    end
    edge_n++;
    pp = evt[0];
    sp = evt[1];
    case (m_state)
      0: begin
        if (pp) begin
          m_state = 1;
          m_spd   = 0;
          m_fault = 0;
          mark    = edge_n;
        end
      end
      1: begin
        if (pp) begin
          m_state    = 2;
          stop_start = edge_n;
        end else if (sp) begin
          m_spd = !m_spd;
          mark  = edge_n;
        end else if (state_in != 2'b00) begin
          mark = edge_n;
        end else if (edge_n - mark == AUTO) begin
          m_state    = 2;
          stop_start = edge_n;
        end
      end
      default: begin
        if (state_in == 2'b00) begin
          m_state = 0;
          m_spd   = 0;
        end else if (edge_n - stop_start == STOP) begin
          m_state = 0;
          m_spd   = 0;
          m_fault = 1;
        end
      end
    endcase
    raw[0] = btn_power;
    raw[1] = btn_speed;
    for (int b = 0; b < 2; b++) begin
      hist[b] = {hist[b][30:0], raw[b]};
      evt[b]  = 0;
      // bit k of hist is the raw sample from k edges ago; the
      // debouncer sees samples two edges old
      if (edge_n - last_chg[b] >= D) begin
        ok = 1;
        for (int k = 2; k < D + 2; k++)
          if (hist[b][k] == deb[b]) ok = 0;
        if (ok) begin
          deb[b]      = !deb[b];
          evt[b]      = deb[b];
          last_chg[b] = edge_n;
        end
      end
    end
  endtask

  task automatic compare_model();
    check("on_off", on_off, m_state == 1);
    check("speed", speed, m_spd);
    check("door_lock", door_lock, m_state != 0);
    check("fault", fault, m_fault);
    check("panel_state", panel_state, m_state);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press_power(input int len);
    btn_power = 1'b1;
    ticks(len);
    btn_power = 1'b0;
  endtask

  int p_left;
  int s_left;

  initial begin
    model_reset();
    ticks(2);
    check("rst_on_off", on_off, 0);
    check("rst_door", door_lock, 0);
    check("rst_panel", panel_state, 0);
    rst = 1'b1;

    // 1: power press latency
    state_in  = 2'b01;
    btn_power = 1'b1;
    ticks(6);
    check("t1_edge6_on", on_off, 0);
    tick();
    check("t1_edge7_on", on_off, 1);
    check("t1_edge7_lock", door_lock, 1);
    check("t1_edge7_panel", panel_state, 2'b01);
    ticks(3);
    btn_power = 1'b0;
    ticks(12);
    check("t1_single", panel_state, 2'b01);

    // 2: bounce rejection then clean speed press
    for (int i = 0; i < 12; i++) begin
      btn_speed = ~btn_speed;
      tick();
    end
    btn_speed = 1'b1;
    ticks(3);
    btn_speed = 1'b0;
    ticks(8);
    check("t2_bounce_spd", speed, 0);
    btn_speed = 1'b1;
    ticks(6);
    check("t2_edge6_spd", speed, 0);
    btn_speed = 1'b0;
    tick();
    check("t2_edge7_spd", speed, 1);
    ticks(10);

    // 3: power-down handshake
    press_power(6);
    tick();
    check("t3_on_off", on_off, 0);
    check("t3_panel", panel_state, 2'b10);
    check("t3_lock", door_lock, 1);
    ticks(5);
    state_in = 2'b00;
    tick();
    check("t3_off_panel", panel_state, 2'b00);
    check("t3_off_spd", speed, 0);
    check("t3_off_lock", door_lock, 0);
    check("t3_off_fault", fault, 0);
    ticks(10);

    // 4: stop timeout
    state_in = 2'b10;
    press_power(6);
    tick();
    ticks(8);
    press_power(6);
    tick();
    check("t4_stopping", panel_state, 2'b10);
    ticks(31);
    check("t4_edge31", panel_state, 2'b10);
    tick();
    check("t4_timeout_panel", panel_state, 2'b00);
    check("t4_fault", fault, 1);
    ticks(4);
    press_power(6);
    tick();
    check("t4_on_again", panel_state, 2'b01);
    check("t4_fault_clr", fault, 0);
    ticks(8);

    // 5a: auto-off after 64 idle cycles
    press_power(6);
    tick();
    state_in = 2'b00;
    tick();
    check("t5_off", panel_state, 2'b00);
    ticks(10);
    press_power(6);
    tick();
    check("t5_on", panel_state, 2'b01);
    ticks(63);
    check("t5_edge63", panel_state, 2'b01);
    tick();
    check("t5_auto_off", panel_state, 2'b10);
    tick();
    check("t5_auto_done", panel_state, 2'b00);
    ticks(4);

    // 5b: simultaneous presses while ON
    state_in = 2'b01;
    press_power(6);
    tick();
    ticks(8);
    btn_speed = 1'b1;
    ticks(6);
    btn_speed = 1'b0;
    tick();
    check("t5_spd_set", speed, 1);
    ticks(8);
    btn_power = 1'b1;
    btn_speed = 1'b1;
    ticks(6);
    btn_power = 1'b0;
    btn_speed = 1'b0;
    tick();
    check("t5_both_panel", panel_state, 2'b10);
    check("t5_both_spd", speed, 1);

    // 6: async reset between edges
    ticks(3);
    #2;
    rst = 1'b0;
    #1;
    check("t6_on_off", on_off, 0);
    check("t6_speed", speed, 0);
    check("t6_lock", door_lock, 0);
    check("t6_fault", fault, 0);
    check("t6_panel", panel_state, 0);
    model_reset();
    ticks(2);
    rst = 1'b1;

    // random traffic
    p_left = 0;
    s_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (p_left == 0) begin
        btn_power = $urandom_range(0, 2) == 0;
        p_left    = $urandom_range(1, 10);
      end
      if (s_left == 0) begin
        btn_speed = $urandom_range(0, 2) == 0;
        s_left    = $urandom_range(1, 10);
      end
      p_left--;
      s_left--;
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 1) == 0) state_in = 2'b00;
        else state_in = 2'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
